cpu_bus_unit: RTL and testbench
===============================

# cpu_bus_unit

Bus interface unit for the x86 core: accepts a memory request of 1..MAX_BYTES bytes addressed as segment:offset, forms 20-bit physical addresses, and sequences it as little-endian byte cycles on the core's 8-bit memory pins. It sits between the core's execution/fetch logic and the external RAM port of `cpu`. It generalises the bare pin bus to multi-byte transfers with x86 offset and A20 wrap-around, and adds a chip-enable stall.

## Interface
- ADDR_W, 20, physical address width; pin_a width
- MAX_BYTES, 4, maximum bytes per request; DATA_W = 8*MAX_BYTES
- SZ_W, $clog2(MAX_BYTES) (min 1), width of req_size
- pin_clock  in  1  clock, all logic on rising edge
- pin_reset  in  1  asynchronous, active-high reset
- pin_ce  in  1  chip enable; low freezes all state
- req  in  1  request strobe, sampled only in IDLE with pin_ce=1
- req_we  in  1  1 = write, 0 = read
- req_size  in  SZ_W  byte count minus 1 (0 = 1 byte)
- req_seg  in  16  segment
- req_off  in  16  offset of first byte
- req_wdata  in  DATA_W  write data, byte 0 in bits [7:0]
- busy  out  1  state != IDLE (combinational from state register)
- done  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read result, valid from done onward until next accept
- pin_a  out  ADDR_W  memory address
- pin_i  in  8  memory read data, valid one clock after pin_a (synchronous RAM)
- pin_o  out  8  memory write data
- pin_w  out  1  memory write enable

## Operation
- Reset values: pin_a=0, pin_o=0, pin_w=0, done=0, rdata=0, state=IDLE, busy=0.
- States: IDLE, RD_WAIT, RD_CAP, WR.
- Physical address: phys(off) = ({seg,4'b0} + {4'b0,off}) mod 2^ADDR_W (A20 wrap when ADDR_W=20).
- Offset of byte k = (req_off + k) mod 2^16; segment never changes within a request.
- IDLE, req=1: latch seg/off/size/we/wdata, byte counter cnt=0, pin_a<=phys(off). Read: rdata<=0, state<=RD_WAIT. Write: pin_o<=wdata[7:0], pin_w<=1, state<=WR.
- RD_WAIT: state<=RD_CAP (RAM latency cycle).
- RD_CAP: rdata[8*cnt+:8]<=pin_i. If cnt==size: done<=1, state<=IDLE. Else cnt++, off++, pin_a<=phys(off+1), state<=RD_WAIT.
- WR (RAM samples pin_w/pin_a/pin_o at this edge): if cnt==size: pin_w<=0, done<=1, state<=IDLE. Else cnt++, off++, pin_a<=phys(off+1), pin_o<=wdata[8*(cnt+1)+:8].
- done is cleared on every other enabled edge.
- req while busy is ignored (not queued). req_size > MAX_BYTES-1 is clamped to MAX_BYTES-1.
- Unused upper rdata bytes read as 0.
- pin_a holds its last value in IDLE; pin_o holds its last value.

## Timing
- Accept edge = E0. Read of N bytes: done high in the cycle after edge E(2N); 2 cycles per byte.
- Write of N bytes: pin_w high from E0 to E(N); done high in the cycle after E(N); 1 cycle per byte.
- Back-to-back: in the done cycle state is IDLE, so a req present then is accepted at the next edge (no dead cycle beyond the done cycle).
- pin_ce=0: no state, counter, output or done change; pin_w is gated to 0 combinationally while pin_ce=0 so RAM does not write twice; done, if high, remains high until the next enabled edge.
- pin_reset mid-transaction: immediate return to reset values; no done is emitted; partial writes already committed stay in RAM.

## Test plan
- Byte read: RAM[0x12345]=0xA5, seg=0x1234 off=0x0005 size=0 -> pin_a=0x12345, done after 2 cycles, rdata=0x000000A5.
- Word read with offset wrap: seg=0x2000 off=0xFFFF size=1, RAM[0x2FFFF]=0x34, RAM[0x20000]=0x12 -> pin_a sequence 0x2FFFF, 0x20000; rdata=0x00001234.
- Dword write: seg=0x0000 off=0x0100 wdata=0xDEADBEEF size=3 -> RAM[0x100..0x103]=EF,BE,AD,DE; pin_w high exactly 4 cycles; done on 5th.
- A20 wrap: seg=0xFFFF off=0x0010 size=0 read -> pin_a=0x00000.
- CE stall: drop pin_ce for 3 cycles after 2nd byte of a dword write -> pin_w=0 during stall, no duplicate write, total latency +3, RAM contents correct.
- Reset mid-read: assert pin_reset in RD_WAIT of byte 1 -> busy=0, done never pulses, rdata=0, next request completes normally.

Source files
------------

// File: rtl/cpu_bus_unit.sv
// cpu_bus_unit: bus interface unit for the x86 core.
// Takes a 1..MAX_BYTES byte request addressed as segment:offset and plays it
// out as little-endian byte cycles on the core's 8-bit synchronous RAM pins.
// The offset wraps at 64 KiB within the segment, and the physical address
// wraps at 2^ADDR_W (A20 wrap for ADDR_W = 20).
//
// Ports:
//   pin_clock   clock, rising edge
//   pin_reset   asynchronous active-high reset
//   pin_ce      chip enable; low freezes every register and masks pin_w
//   req         request strobe, taken only when idle and enabled
//   req_we      1 = write, 0 = read
//   req_size    byte count minus one (clamped to MAX_BYTES-1)
//   req_seg     segment
//   req_off     offset of the first byte
//   req_wdata   write data, byte 0 in [7:0]
//   busy        transfer in progress
//   done        one-cycle completion pulse
//   rdata       read result, held until the next read is accepted
//   pin_a       RAM address
//   pin_i       RAM read data, one clock after pin_a
//   pin_o       RAM write data
//   pin_w       RAM write enable
module cpu_bus_unit #(
  parameter int ADDR_W    = 20,
  parameter int MAX_BYTES = 4,
  parameter int SZ_W      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input  logic                   pin_clock,
  input  logic                   pin_reset,
  input  logic                   pin_ce,
  input  logic                   req,
  input  logic                   req_we,
  input  logic [SZ_W-1:0]        req_size,
  input  logic [15:0]            req_seg,
  input  logic [15:0]            req_off,
  input  logic [8*MAX_BYTES-1:0] req_wdata,
  output logic                   busy,
  output logic                   done,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic [ADDR_W-1:0]      pin_a,
  input  logic [7:0]             pin_i,
  output logic [7:0]             pin_o,
  output logic                   pin_w
);

  localparam int DATA_W = 8 * MAX_BYTES;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP, WR} state_t;

  state_t              state, state_d;
  logic [SZ_W-1:0]     cnt, cnt_d;
  logic [SZ_W-1:0]     size, size_d;
  logic [15:0]         seg, seg_d;
  logic [15:0]         off, off_d, off_n;
  logic [DATA_W-1:0]   wdata, wdata_d;
  logic [DATA_W-1:0]   rdata_d;
  logic [ADDR_W-1:0]   pin_a_d;
  logic [7:0]          pin_o_d;
  logic                wen, wen_d;
  logic                done_d;

  // Real-mode address formation; the sum is truncated to ADDR_W bits.
  function automatic logic [ADDR_W-1:0] phys(input logic [15:0] s,
                                             input logic [15:0] o);
    return ADDR_W'({s, 4'b0000}) + ADDR_W'(o);
  endfunction

  function automatic logic [SZ_W-1:0] clamp_size(input logic [SZ_W-1:0] s);
    if (int'(s) > MAX_BYTES - 1) return SZ_W'(MAX_BYTES - 1);
    return s;
  endfunction

  assign busy = (state != IDLE);

  // The registered write enable stays high through a stall; masking it here
  // keeps the RAM from committing the same byte on every frozen cycle.
  assign pin_w = wen & pin_ce;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    size_d  = size;
    seg_d   = seg;
    off_d   = off;
    off_n   = off + 16'd1;
    wdata_d = wdata;
    rdata_d = rdata;
    pin_a_d = pin_a;
    pin_o_d = pin_o;
    wen_d   = wen;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          seg_d   = req_seg;
          off_d   = req_off;
          size_d  = clamp_size(req_size);
          wdata_d = req_wdata;
          cnt_d   = '0;
          pin_a_d = phys(req_seg, req_off);
          if (req_we) begin
            pin_o_d = req_wdata[7:0];
            wen_d   = 1'b1;
            state_d = WR;
          end else begin
            rdata_d = '0;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: state_d = RD_CAP;
      RD_CAP: begin
        rdata_d[8*int'(cnt) +: 8] = pin_i;
        if (cnt == size) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt + SZ_W'(1);
          off_d   = off_n;
          pin_a_d = phys(seg, off_n);
          state_d = RD_WAIT;
        end
      end
      WR: begin
        if (cnt == size) begin
          wen_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt + SZ_W'(1);
          off_d   = off_n;
          pin_a_d = phys(seg, off_n);
          pin_o_d = wdata[8*(int'(cnt) + 1) +: 8];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible outputs: reset to known values, frozen when pin_ce=0.
  always_ff @(posedge pin_clock or posedge pin_reset) begin
    if (pin_reset) begin
      state <= IDLE;
      cnt   <= '0;
      wen   <= 1'b0;
      done  <= 1'b0;
      rdata <= '0;
      pin_a <= '0;
      pin_o <= '0;
    end else if (pin_ce) begin
      state <= state_d;
      cnt   <= cnt_d;
      wen   <= wen_d;
      done  <= done_d;
      rdata <= rdata_d;
      pin_a <= pin_a_d;
      pin_o <= pin_o_d;
    end
  end

  // Request latches: only read while busy, so they need no reset.
  always_ff @(posedge pin_clock) begin
    if (pin_ce) begin
      size  <= size_d;
      seg   <= seg_d;
      off   <= off_d;
      wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_unit.sv
// Bench for cpu_bus_unit: directed vector table, hand-written stall / reset /
// ignored-request sequences, then randomized transfers with random chip-enable
// stalls checked against a byte-array model of memory.
module tb_cpu_bus_unit;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        req;
  logic        req_we;
  logic [1:0]  req_size;
  logic [15:0] req_seg;
  logic [15:0] req_off;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [19:0] pin_a;
  logic [7:0]  pin_i;
  logic [7:0]  pin_o;
  logic        pin_w;

  int nvec = 0;
  int nerr = 0;

  logic [7:0]  mem     [0:1048575];
  logic [7:0]  ref_mem [0:1048575];
  logic [27:0] wlog[$];

  cpu_bus_unit #(.ADDR_W(20), .MAX_BYTES(4)) dut (
    .pin_clock(clk),
    .pin_reset(rst),
    .pin_ce(ce),
    .req(req),
    .req_we(req_we),
    .req_size(req_size),
    .req_seg(req_seg),
    .req_off(req_off),
    .req_wdata(req_wdata),
    .busy(busy),
    .done(done),
    .rdata(rdata),
    .pin_a(pin_a),
    .pin_i(pin_i),
    .pin_o(pin_o),
    .pin_w(pin_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 7) ^ (i >> 8) ^ 8'h5A);
  endfunction

  function automatic int phys_ref(input logic [15:0] s, input int o);
    return ((int'(s) * 16) + (o & 'hFFFF)) % (1 << 20);
  endfunction

  // Synchronous RAM: write and read both sample pins at the rising edge.
  initial begin
    for (int i = 0; i < 1048576; i++) mem[i] = init_byte(i);
    pin_i <= 8'h00;
    forever begin
      @(posedge clk);
      pin_i <= mem[pin_a];
      if (pin_w) mem[pin_a] = pin_o;
    end
  end

  always @(posedge clk) if (pin_w) wlog.push_back({pin_a, pin_o});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_req(input string nm, input bit we, input int size,
                         input logic [15:0] seg, input logic [15:0] off,
                         input logic [31:0] wd, input bit chk_a0,
                         input logic [19:0] a0, input bit has_exp,
                         input logic [31:0] expd, input int stall_at,
                         input int stall_len, input bit rnd_ce, input bit poke);
    int n;
    int addr[4];
    logic [31:0] exp_v;
    logic [19:0] exp_a0;
    int en_e;
    int tot;
    int stall_left;
    bit stalled;
    bit seen;
    bit poked;
    int lat;
    n = size + 1;
    exp_v = 32'h0;
    en_e = 0; tot = 0; stall_left = 0; stalled = 0; seen = 0; poked = 0;
    for (int k = 0; k < n; k++) begin
      addr[k] = phys_ref(seg, int'(off) + k);
      if (!we) exp_v[8*k +: 8] = ref_mem[addr[k]];
    end
    if (we) exp_v = wd;
    if (has_exp) exp_v = expd;
    exp_a0 = chk_a0 ? a0 : 20'(addr[0]);
    wlog.delete();

    req = 1'b1; req_we = we; req_size = 2'(size);
    req_seg = seg; req_off = off; req_wdata = wd; ce = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk({nm, " busy after accept"}, 64'(busy), 64'd1);
    chk({nm, " first pin_a"}, 64'(pin_a), 64'(exp_a0));

    for (int i = 0; i < 100 && !seen; i++) begin
      if (stall_len > 0 && !stalled && stall_left == 0 && en_e == stall_at) begin
        stall_left = stall_len;
        stalled = 1'b1;
      end
      if (stall_left > 0) begin
        ce = 1'b0;
        stall_left--;
      end else if (rnd_ce) ce = ($urandom_range(0, 3) != 0);
      else ce = 1'b1;
      if (poke && !poked && en_e == 1) begin
        req = 1'b1; req_we = ~we; req_seg = ~seg; req_off = ~off;
        poked = 1'b1;
      end else req = 1'b0;
      @(posedge clk);
      tot++;
      if (ce) en_e++;
      #1;
      if (!ce) chk({nm, " pin_w masked in stall"}, 64'(pin_w), 64'd0);
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    ce = 1'b1;
    req = 1'b0;

    if (!seen) begin
      nvec++;
      nerr++;
      $display("FAIL %s done timeout: got no done, expected done", nm);
    end else begin
      lat = we ? n : 2 * n;
      chk({nm, " latency"}, 64'(en_e), 64'(lat));
      if (stall_len > 0 && !rnd_ce) chk({nm, " stalled latency"}, 64'(tot), 64'(lat + stall_len));
      if (!we) begin
        chk({nm, " rdata"}, 64'(rdata), 64'(exp_v));
        chk({nm, " no write during read"}, 64'(wlog.size()), 64'd0);
      end else begin
        chk({nm, " write count"}, 64'(wlog.size()), 64'(n));
        for (int k = 0; k < n; k++) begin
          if (k < wlog.size())
            chk({nm, " write cycle"}, 64'(wlog[k]), 64'({20'(addr[k]), exp_v[8*k +: 8]}));
          chk({nm, " ram byte"}, 64'(mem[addr[k]]), 64'(exp_v[8*k +: 8]));
          ref_mem[addr[k]] = wd[8*k +: 8];
        end
      end
      if (poke) begin
        @(negedge clk);
        chk({nm, " done one cycle"}, 64'(done), 64'd0);
        chk({nm, " extra req not queued"}, 64'(busy), 64'd0);
      end
    end
  endtask

  typedef struct {
    bit          we;
    int          size;
    logic [15:0] seg;
    logic [15:0] off;
    logic [31:0] wd;
    logic [19:0] a0;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[9];

  bit          r_we;
  int          r_sz;
  logic [15:0] r_seg;
  logic [15:0] r_off;
  logic [31:0] r_wd;
  bit          saw_done;

  initial begin
    for (int i = 0; i < 1048576; i++) ref_mem[i] = init_byte(i);

    tbl[0] = '{1'b1, 0, 16'h1234, 16'h0005, 32'h000000A5, 20'h12345, 32'h000000A5};
    tbl[1] = '{1'b0, 0, 16'h1234, 16'h0005, 32'h0,        20'h12345, 32'h000000A5};
    tbl[2] = '{1'b1, 1, 16'h2000, 16'hFFFF, 32'h00001234, 20'h2FFFF, 32'h00001234};
    tbl[3] = '{1'b0, 1, 16'h2000, 16'hFFFF, 32'h0,        20'h2FFFF, 32'h00001234};
    tbl[4] = '{1'b1, 3, 16'h0000, 16'h0100, 32'hDEADBEEF, 20'h00100, 32'hDEADBEEF};
    tbl[5] = '{1'b0, 3, 16'h0000, 16'h0100, 32'h0,        20'h00100, 32'hDEADBEEF};
    tbl[6] = '{1'b1, 0, 16'hFFFF, 16'h0010, 32'h0000005A, 20'h00000, 32'h0000005A};
    tbl[7] = '{1'b0, 0, 16'hFFFF, 16'h0010, 32'h0,        20'h00000, 32'h0000005A};
    tbl[8] = '{1'b0, 2, 16'h0000, 16'h0101, 32'h0,        20'h00101, 32'h00DEADBE};

    rst = 1'b1; ce = 1'b1; req = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_seg = 16'h0; req_off = 16'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset rdata", 64'(rdata), 64'd0);
    chk("reset pin_a", 64'(pin_a), 64'd0);
    chk("reset pin_o", 64'(pin_o), 64'd0);
    chk("reset pin_w", 64'(pin_w), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table entries run back to back: each request is raised in the done cycle
    // of the previous one.
    for (int v = 0; v < 9; v++)
      run_req($sformatf("vec%0d", v), tbl[v].we, tbl[v].size, tbl[v].seg, tbl[v].off,
              tbl[v].wd, 1'b1, tbl[v].a0, 1'b1, tbl[v].exp, 0, 0, 1'b0, 1'b0);

    // Chip-enable stall of three cycles after the second written byte.
    run_req("ce_stall_wr", 1'b1, 3, 16'h0000, 16'h0200, 32'h11223344,
            1'b1, 20'h00200, 1'b1, 32'h11223344, 2, 3, 1'b0, 1'b0);
    run_req("ce_stall_rd", 1'b0, 3, 16'h0000, 16'h0200, 32'h0,
            1'b1, 20'h00200, 1'b1, 32'h11223344, 3, 2, 1'b0, 1'b0);

    // A second request while busy is dropped, and done lasts one cycle.
    run_req("busy_req", 1'b0, 3, 16'h0000, 16'h0100, 32'h0,
            1'b1, 20'h00100, 1'b1, 32'hDEADBEEF, 0, 0, 1'b0, 1'b1);

    // Reset in the latency cycle of the second byte of a word read.
    req = 1'b1; req_we = 1'b0; req_size = 2'd1; req_seg = 16'h0000; req_off = 16'h0100;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset rdata", 64'(rdata), 64'd0);
    chk("midreset pin_a", 64'(pin_a), 64'd0);
    chk("midreset done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("midreset no done", 64'(saw_done), 64'd0);
    run_req("after_reset", 1'b0, 3, 16'h0000, 16'h0100, 32'h0,
            1'b1, 20'h00100, 1'b1, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0);

    // Random transfers with random chip-enable stalls, biased toward offset
    // and A20 wrap.
    for (int t = 0; t < 80; t++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_sz  = int'($urandom_range(0, 3));
      r_seg = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 1)) : 16'($urandom);
      r_off = ($urandom_range(0, 2) == 0) ? 16'hFFFD + 16'($urandom_range(0, 2)) : 16'($urandom);
      r_wd  = $urandom;
      run_req($sformatf("rnd%0d", t), r_we, r_sz, r_seg, r_off, r_wd,
              1'b0, 20'h0, 1'b0, 32'h0, 0, 0, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
